// File: rtl/contador_pc_pkg.sv
// Shared definitions for the contador_pc program-counter stage: state encoding,
// default datapath width and the byte-to-word shift applied to branch offsets.
package contador_pc_pkg;

   localparam int PC_W_DEF   = 32;
   localparam int CNT_W      = 32;
   localparam int WORD_SHIFT = 2;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_STALL = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;

   // Byte offsets use the RISC-V encoding, so a word offset is an arithmetic shift.
   function automatic logic [PC_W_DEF-1:0] word_offset(input logic [PC_W_DEF-1:0] byte_off);
      return $unsigned($signed(byte_off) >>> WORD_SHIFT);
   endfunction

endpackage

// File: rtl/contador_pc_if.sv
// Fetch-side bundle of contador_pc: redirect/stall controls in, PC and status out.
// The slave modport is the PC stage; the master modport is its environment.
interface contador_pc_if #(
   parameter int PC_W = 32
);
   logic             stall;
   logic             redirect;
   logic [PC_W-1:0]  imm_off;
   logic [PC_W-1:0]  base_pc;
   logic [PC_W-1:0]  PC;
   logic             pc_valid;
   logic             halted;
   logic             bad_target;
   logic [31:0]      cycle_cnt;
   logic [31:0]      redir_cnt;

   modport master (
      output stall, redirect, imm_off, base_pc,
      input  PC, pc_valid, halted, bad_target, cycle_cnt, redir_cnt
   );

   modport slave (
      input  stall, redirect, imm_off, base_pc,
      output PC, pc_valid, halted, bad_target, cycle_cnt, redir_cnt
   );
endinterface

// File: rtl/contador_pc_perf.sv
// Free-running performance counters for contador_pc: active cycles and accepted
// redirects. Both wrap naturally and clear on the synchronous reset.
module pc_perf_counters
   import contador_pc_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             count_cycle,
   input  logic             count_redir,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] redir_cnt
);

   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_cnt <= '0;
         redir_cnt <= '0;
      end else begin
         if (count_cycle) cycle_cnt <= cycle_cnt + 1'b1;
         if (count_redir) redir_cnt <= redir_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/contador_pc.sv
// Program counter feeding instruction fetch: advance, hold on stall, or redirect.
// Define PC_PERF_EN to add the cycle/redirect counters; otherwise they read zero.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_RUN   | PC advances each cycle, halts after the last instruction
//   ST_STALL | PC held; release returns to RUN without incrementing
//   ST_HALT  | program done or bad redirect; frozen until reset
module contador_pc
   import contador_pc_pkg::*;
#(
   parameter int PC_W      = PC_W_DEF,
   parameter int NUM_INSTR = 7,
   parameter int RESET_PC  = 0
) (
   input  logic          clk,
   input  logic          reset,
   contador_pc_if.slave  bus
);

   localparam logic [PC_W-1:0] PC_INIT = PC_W'(RESET_PC);
   localparam logic [PC_W-1:0] PC_LAST = PC_W'(NUM_INSTR - 1);
   localparam logic [PC_W-1:0] PC_END  = PC_W'(NUM_INSTR);

   logic [1:0]      state;
   logic [PC_W-1:0] pc;
   logic            valid;
   logic            halt;
   logic            bad;
   logic [PC_W-1:0] imm_word;
   logic [PC_W-1:0] tgt;
   logic            tgt_ok;

   assign imm_word = $unsigned($signed(bus.imm_off) >>> WORD_SHIFT);
   assign tgt      = bus.base_pc + imm_word;
   // Unsigned compare: a backward branch that wraps below zero lands far out of range.
   assign tgt_ok   = (tgt < PC_END);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_RUN;
         pc    <= PC_INIT;
         valid <= 1'b1;
         halt  <= 1'b0;
         bad   <= 1'b0;
      end else begin
         case (state)
            ST_RUN, ST_STALL: begin
               if (bus.redirect) begin
                  if (tgt_ok) begin
                     pc    <= tgt;
                     state <= ST_RUN;
                  end else begin
                     bad   <= 1'b1;
                     state <= ST_HALT;
                     valid <= 1'b0;
                     halt  <= 1'b1;
                  end
               end else if (bus.stall) begin
                  state <= ST_STALL;
               end else if (state == ST_STALL) begin
                  state <= ST_RUN;
               end else if (pc == PC_LAST) begin
                  state <= ST_HALT;
                  valid <= 1'b0;
                  halt  <= 1'b1;
               end else begin
                  pc <= pc + 1'b1;
               end
            end
            ST_HALT: begin
            end
            default: begin
               state <= ST_HALT;
               valid <= 1'b0;
               halt  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.PC         = pc;
   assign bus.pc_valid   = valid;
   assign bus.halted     = halt;
   assign bus.bad_target = bad;

`ifdef PC_PERF_EN
   logic count_cycle;
   logic count_redir;

   assign count_cycle = (state != ST_HALT);
   assign count_redir = (state != ST_HALT) && bus.redirect && tgt_ok;

   pc_perf_counters u_perf (
      .clk         (clk),
      .reset       (reset),
      .count_cycle (count_cycle),
      .count_redir (count_redir),
      .cycle_cnt   (bus.cycle_cnt),
      .redir_cnt   (bus.redir_cnt)
   );
`else
   assign bus.cycle_cnt = '0;
   assign bus.redir_cnt = '0;
`endif

endmodule
